// File: rtl/systolic_writeback_engine.sv
// Result-drain/writeback stage: captures one accumulator row, requantises each
// lane (shift, optional ReLU, saturate or wrap) and writes the words to memory
// row-major or transposed, with a ready handshake and single-step mode.
module systolic_writeback_engine #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            addr_C,
  input  logic [8:0]                   dim,
  input  logic [$clog2(ACC_WIDTH)-1:0] shift_amt,
  input  logic                         relu_en,
  input  logic                         sat_en,
  input  logic                         transpose,
  input  logic                         col_valid,
  input  logic [N*ACC_WIDTH-1:0]       col_data,
  output logic                         col_ready,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WIDTH-1:0]             mem_data_write,
  input  logic                         mem_ready,
  input  logic                         step_en,
  input  logic                         step,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow_out,
  output logic [15:0]                  ovf_count,
  output logic [15:0]                  total_cycles
);

  localparam int unsigned SW = $clog2(ACC_WIDTH);
  localparam int unsigned DW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_WAIT_STEP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  state_e              dest_q, dest_d;
  logic [IW-1:0]       row_q, row_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DW-1:0]       dim_q, dim_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic                relu_q, relu_d;
  logic                sat_q, sat_d;
  logic                tr_q, tr_d;
  logic [WIDTH-1:0]    buf_q [N];
  logic [WIDTH-1:0]    buf_d [N];
  logic [N-1:0]        lovf_q, lovf_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         ovf_cnt_q, ovf_cnt_d;
  logic [15:0]         tcyc_q, tcyc_d;
  logic                col_ready_q, col_ready_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DW-1:0]       dim_clamp_c;
  logic [WIDTH:0]      lane_res_c [N];

  // Requantise one lane; returns {out_of_range, word}.
  function automatic logic [WIDTH:0] proc_lane(
    input logic signed [ACC_WIDTH-1:0] lane,
    input logic [SW-1:0]               sh,
    input logic                        relu,
    input logic                        sat
  );
    logic signed [ACC_WIDTH-1:0] v;
    logic signed [ACC_WIDTH-1:0] vmax;
    logic signed [ACC_WIDTH-1:0] vmin;
    logic                        ov;
    logic [WIDTH-1:0]            word;
    vmax = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    vmin = ~vmax;
    v    = lane >>> sh;
    if (relu && (v < 0)) v = '0;
    ov   = (v > vmax) || (v < vmin);
    if (sat && ov) word = v[ACC_WIDTH-1] ? vmin[WIDTH-1:0] : vmax[WIDTH-1:0];
    else           word = v[WIDTH-1:0];
    return {ov, word};
  endfunction

  // Runtime dimension clamped to the physical lane count.
  always_comb begin
    dim_clamp_c = (dim > 9'(N)) ? DW'(N) : DW'(dim);
  end

  // Per-lane datapath using the configuration latched at job start.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      lane_res_c[i] = proc_lane(col_data[i*ACC_WIDTH +: ACC_WIDTH], shift_q, relu_q, sat_q);
    end
  end

  // Next-state, counters and next registered outputs.
  always_comb begin
    logic [ADDR_W-1:0] a_row;
    logic [ADDR_W-1:0] a_idx;
    logic [ADDR_W-1:0] a_dim;
    state_e            nxt;

    state_d    = state_q;
    dest_d     = dest_q;
    row_d      = row_q;
    idx_d      = idx_q;
    dim_d      = dim_q;
    base_d     = base_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    sat_d      = sat_q;
    tr_d       = tr_q;
    buf_d      = buf_q;
    lovf_d     = lovf_q;
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    tcyc_d     = tcyc_q;
    nxt        = state_q;

    if ((state_q != S_IDLE) && (tcyc_q != 16'hFFFF)) tcyc_d = tcyc_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = addr_C;
          dim_d      = dim_clamp_c;
          shift_d    = shift_amt;
          relu_d     = relu_en;
          sat_d      = sat_en;
          tr_d       = transpose;
          overflow_d = 1'b0;
          ovf_cnt_d  = '0;
          tcyc_d     = '0;
          row_d      = '0;
          idx_d      = '0;
          state_d    = (dim_clamp_c == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (col_valid) begin
          for (int i = 0; i < int'(N); i++) begin
            buf_d[i]  = lane_res_c[i][WIDTH-1:0];
            lovf_d[i] = lane_res_c[i][WIDTH];
          end
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (lovf_q[idx_q]) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
          end
          if (DW'(idx_q) < (dim_q - DW'(1))) begin
            idx_d = idx_q + IW'(1);
            nxt   = S_WRITE;
          end else if (DW'(row_q) < (dim_q - DW'(1))) begin
            row_d = row_q + IW'(1);
            nxt   = S_CAPTURE;
          end else begin
            nxt   = S_DONE;
          end
          if (step_en) begin
            dest_d  = nxt;
            state_d = S_WAIT_STEP;
          end else begin
            state_d = nxt;
          end
        end
      end
      S_WAIT_STEP: begin
        if (step) state_d = dest_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    a_row = ADDR_W'(row_d);
    a_idx = ADDR_W'(idx_d);
    a_dim = ADDR_W'(dim_d);

    col_ready_d = (state_d == S_CAPTURE);
    mem_write_d = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_addr_d  = '0;
    mem_data_d  = '0;
    if (mem_write_d) begin
      mem_addr_d = tr_d ? (base_d + a_idx * a_dim + a_row)
                        : (base_d + a_row * a_dim + a_idx);
      mem_data_d = buf_d[idx_d];
    end
  end

  // State, configuration, row buffer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dest_q      <= S_IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      dim_q       <= '0;
      base_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      sat_q       <= 1'b0;
      tr_q        <= 1'b0;
      for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
      lovf_q      <= '0;
      overflow_q  <= 1'b0;
      ovf_cnt_q   <= '0;
      tcyc_q      <= '0;
      col_ready_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      dim_q       <= dim_d;
      base_q      <= base_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      sat_q       <= sat_d;
      tr_q        <= tr_d;
      for (int i = 0; i < int'(N); i++) buf_q[i] <= buf_d[i];
      lovf_q      <= lovf_d;
      overflow_q  <= overflow_d;
      ovf_cnt_q   <= ovf_cnt_d;
      tcyc_q      <= tcyc_d;
      col_ready_q <= col_ready_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign col_ready      = col_ready_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_write = mem_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overflow_out   = overflow_q;
  assign ovf_count      = ovf_cnt_q;
  assign total_cycles   = tcyc_q;

endmodule

// File: tb/tb_systolic_writeback_engine.sv
// Bench for systolic_writeback_engine: vector table of jobs with expected
// write streams fed to a scoreboard, plus hand sequences for abort/dim=0.
module tb_systolic_writeback_engine;

  logic         clk;
  logic         rst;
  logic         start;
  logic [11:0]  addr_C;
  logic [8:0]   dim;
  logic [4:0]   shift_amt;
  logic         relu_en;
  logic         sat_en;
  logic         transpose;
  logic         col_valid;
  logic [127:0] col_data;
  logic         col_ready;
  logic         mem_write;
  logic [11:0]  mem_addr;
  logic [15:0]  mem_data_write;
  logic         mem_ready;
  logic         step_en;
  logic         step;
  logic         busy;
  logic         done;
  logic         overflow_out;
  logic [15:0]  ovf_count;
  logic [15:0]  total_cycles;

  systolic_writeback_engine #(
    .N(4), .WIDTH(16), .ACC_WIDTH(32), .ADDR_W(12)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .addr_C(addr_C), .dim(dim),
    .shift_amt(shift_amt), .relu_en(relu_en), .sat_en(sat_en),
    .transpose(transpose), .col_valid(col_valid), .col_data(col_data),
    .col_ready(col_ready), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data_write(mem_data_write), .mem_ready(mem_ready),
    .step_en(step_en), .step(step), .busy(busy), .done(done),
    .overflow_out(overflow_out), .ovf_count(ovf_count),
    .total_cycles(total_cycles)
  );

  typedef struct packed {
    logic [11:0]            addr;
    logic [8:0]             dim;
    logic [4:0]             shift;
    logic                   relu;
    logic                   sat;
    logic                   tr;
    logic                   stall;
    logic                   stepm;
    logic                   poke;
    logic [3:0][3:0][31:0]  lanes;
    logic [4:0]             nexp;
    logic [15:0][11:0]      ea;
    logic [15:0][15:0]      ed;
    logic [15:0]            eovc;
    logic                   eov;
    logic [15:0]            etc;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int wr_total = 0;
  int exp_a_q[$];
  int exp_d_q[$];
  logic        hold_pend = 1'b0;
  logic [11:0] hold_a;
  logic [15:0] hold_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: scoreboard pop on accepted writes, hold check on stalls.
  initial begin
    int ea, ed;
    forever begin
      @(negedge clk);
      if (hold_pend && mem_write) begin
        chk("hold_addr", mem_addr, hold_a);
        chk("hold_data", mem_data_write, hold_d);
      end
      hold_pend = mem_write && !mem_ready;
      hold_a    = mem_addr;
      hold_d    = mem_data_write;
      if (mem_write && mem_ready) begin
        wr_total++;
        if (exp_a_q.size() == 0) begin
          chk("unexpected_write_addr", mem_addr, -1);
        end else begin
          ea = exp_a_q.pop_front();
          ed = exp_d_q.pop_front();
          chk("write_addr", mem_addr, ea);
          chk("write_data", mem_data_write, ed);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  function automatic vec_t mk(input int a, input int d, input int sh,
                              input bit relu, input bit sat, input bit tr);
    vec_t v;
    v       = '0;
    v.addr  = 12'(a);
    v.dim   = 9'(d);
    v.shift = 5'(sh);
    v.relu  = relu;
    v.sat   = sat;
    v.tr    = tr;
    return v;
  endfunction

  task automatic load_row(input vec_t v, input int r);
    if (r < 4) begin
      for (int l = 0; l < 4; l++) col_data[l*32 +: 32] = v.lanes[r][l];
    end
  endtask

  task automatic run_job(input int id, input vec_t v);
    int  wait_cnt = 0;
    int  cyc = 0;
    int  dones = 0;
    int  jw = 0;
    int  steps = 0;
    int  idle = 0;
    int  cap_ph = 0;
    int  cap_cnt = 0;
    int  r = 0;
    bit  fin = 1'b0;
    bit  poked = 1'b0;
    bit  acc_row, acc_w, w_pend;
    for (int k = 0; k < int'(v.nexp); k++) begin
      exp_a_q.push_back(int'(v.ea[k]));
      exp_d_q.push_back(int'(v.ed[k]));
    end
    addr_C    = v.addr;
    dim       = v.dim;
    shift_amt = v.shift;
    relu_en   = v.relu;
    sat_en    = v.sat;
    transpose = v.tr;
    step_en   = v.stepm;
    step      = 1'b0;
    mem_ready = !v.stall;
    load_row(v, 0);
    col_valid = !v.stepm;
    cap_ph    = v.stepm ? 0 : 2;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    while (!fin && cyc < 600) begin
      step  = 1'b0;
      start = 1'b0;
      if (v.stall) mem_ready = mem_write && (wait_cnt >= 3);
      if (cap_ph == 0 && col_ready) begin
        step   = 1'b1;
        cap_ph = 1;
        cap_cnt = 0;
      end else if (cap_ph == 1) begin
        cap_cnt++;
        if (cap_cnt == 2) begin
          chk($sformatf("v%0d_step_in_capture", id), {col_ready, mem_write}, 2'b10);
          col_valid = 1'b1;
          cap_ph = 2;
        end
      end else if (v.stepm && busy && !mem_write && !col_ready && !done) begin
        idle++;
        if (idle >= 3) begin
          step = 1'b1;
          steps++;
          idle = 0;
        end
      end else begin
        idle = 0;
      end
      if (v.poke && mem_write && !poked) begin
        start  = 1'b1;
        addr_C = v.addr + 12'd64;
        dim    = 9'd3;
        poked  = 1'b1;
      end
      acc_row = col_valid && col_ready;
      acc_w   = mem_write && mem_ready;
      w_pend  = mem_write && !mem_ready;
      if (acc_w) begin
        if (v.stepm) chk($sformatf("v%0d_step_gate", id), jw, steps);
        jw++;
      end
      tick();
      if (acc_row) begin
        r++;
        load_row(v, r);
      end
      if (acc_w) wait_cnt = 0;
      else if (w_pend) wait_cnt++;
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      cyc++;
    end
    step  = 1'b0;
    start = 1'b0;
    chk($sformatf("v%0d_finished", id), fin, 1);
    repeat (2) begin
      tick();
      if (done) dones++;
    end
    step_en = 1'b0;
    chk($sformatf("v%0d_done_pulses", id), dones, 1);
    chk($sformatf("v%0d_busy_after", id), busy, 0);
    chk($sformatf("v%0d_writes_left", id), exp_a_q.size(), 0);
    exp_a_q.delete();
    exp_d_q.delete();
    chk($sformatf("v%0d_ovf_count", id), ovf_count, v.eovc);
    chk($sformatf("v%0d_overflow_out", id), overflow_out, v.eov);
    if (v.etc != 16'd0) chk($sformatf("v%0d_total_cycles", id), total_cycles, v.etc);
  endtask

  initial begin
    vec_t v;
    int   dones;
    int   wr0;
    int   cyc;

    // Job table
    v = mk(32, 4, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      v.lanes[k/4][k%4] = 32'(k + 1);
      v.ea[k] = 12'(32 + k);
      v.ed[k] = 16'(k + 1);
    end
    v.nexp = 5'd16;
    v.etc  = 16'd21;
    vt[0]  = v;

    v = mk(48, 2, 0, 0, 0, 1);
    v.lanes[0] = {32'd100000, 32'd100000, 32'd6, 32'd5};
    v.lanes[1] = {32'd100000, 32'd100000, 32'd8, 32'd7};
    v.ea[0] = 12'd48; v.ed[0] = 16'd5;
    v.ea[1] = 12'd50; v.ed[1] = 16'd6;
    v.ea[2] = 12'd49; v.ed[2] = 16'd7;
    v.ea[3] = 12'd51; v.ed[3] = 16'd8;
    v.nexp = 5'd4;
    vt[1]  = v;

    v = mk(100, 4, 0, 0, 1, 0);
    v.lanes[0] = {32'd70000, 32'(-5), 32'(-40000), 32'd40000};
    for (int k = 0; k < 16; k++) v.ea[k] = 12'(100 + k);
    v.ed[0] = 16'h7FFF; v.ed[1] = 16'h8000; v.ed[2] = 16'hFFFB; v.ed[3] = 16'h7FFF;
    v.nexp = 5'd16;
    v.eovc = 16'd3;
    v.eov  = 1'b1;
    vt[2]  = v;

    v.relu  = 1'b1;
    v.ed[1] = 16'h0000; v.ed[2] = 16'h0000;
    v.eovc  = 16'd2;
    vt[3]   = v;

    v.relu  = 1'b0;
    v.sat   = 1'b0;
    v.ed[0] = 16'h9C40; v.ed[1] = 16'h63C0; v.ed[2] = 16'hFFFB; v.ed[3] = 16'h1170;
    v.eovc  = 16'd3;
    vt[4]   = v;

    v = mk(4094, 2, 4, 0, 0, 0);
    v.lanes[0] = {32'd0, 32'd0, 32'd32, 32'(-17)};
    v.lanes[1] = {32'd0, 32'd0, 32'(-1), 32'd160};
    v.ea[0] = 12'd4094; v.ed[0] = 16'hFFFE;
    v.ea[1] = 12'd4095; v.ed[1] = 16'd2;
    v.ea[2] = 12'd0;    v.ed[2] = 16'd10;
    v.ea[3] = 12'd1;    v.ed[3] = 16'hFFFF;
    v.nexp = 5'd4;
    vt[5]  = v;

    v = mk(200, 2, 0, 0, 0, 0);
    v.stall = 1'b1;
    v.lanes[0] = {32'd0, 32'd0, 32'd12, 32'd11};
    v.lanes[1] = {32'd0, 32'd0, 32'd14, 32'd13};
    for (int k = 0; k < 4; k++) begin
      v.ea[k] = 12'(200 + k);
      v.ed[k] = 16'(11 + k);
    end
    v.nexp = 5'd4;
    vt[6]  = v;

    v = mk(300, 2, 0, 0, 0, 0);
    v.stepm = 1'b1;
    v.lanes[0] = {32'd0, 32'd0, 32'd22, 32'd21};
    v.lanes[1] = {32'd0, 32'd0, 32'd24, 32'd23};
    for (int k = 0; k < 4; k++) begin
      v.ea[k] = 12'(300 + k);
      v.ed[k] = 16'(21 + k);
    end
    v.nexp = 5'd4;
    vt[7]  = v;

    v = vt[0];
    v.addr = 12'd64;
    v.dim  = 9'd9;
    v.poke = 1'b1;
    for (int k = 0; k < 16; k++) v.ea[k] = 12'(64 + k);
    vt[8]  = v;

    // Reset state
    rst = 1'b0; start = 1'b0; addr_C = '0; dim = '0; shift_amt = '0;
    relu_en = 1'b0; sat_en = 1'b0; transpose = 1'b0; col_valid = 1'b0;
    col_data = '0; mem_ready = 1'b0; step_en = 1'b0; step = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_col_ready", col_ready, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_data", mem_data_write, 0);
    chk("reset_ovf", {overflow_out, ovf_count}, 0);
    chk("reset_total_cycles", total_cycles, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_job(i, vt[i]);

    // dim=0: immediate done, no writes
    wr0 = wr_total;
    addr_C = 12'd700; dim = 9'd0; col_valid = 1'b0; mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      tick();
    end
    chk("dim0_done_pulses", dones, 1);
    chk("dim0_no_writes", wr_total, wr0);
    chk("dim0_busy_after", busy, 0);

    // Reset asserted while a word is being presented
    v = vt[0];
    addr_C = 12'd0; dim = 9'd4; shift_amt = '0; relu_en = 1'b0; sat_en = 1'b0;
    transpose = 1'b0; step_en = 1'b0; mem_ready = 1'b1;
    load_row(v, 0);
    col_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!mem_write && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("abort_reached_write", mem_write, 1);
    rst = 1'b0;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_data", mem_data_write, 0);
    chk("abort_col_ready", col_ready, 0);
    chk("abort_total_cycles", total_cycles, 0);
    wr0 = wr_total;
    repeat (3) tick();
    chk("abort_no_writes", wr_total, wr0);
    rst = 1'b1;
    col_valid = 1'b0;
    tick();
    run_job(100, vt[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
